// File: rtl/and_sensitivity_monitor.sv
// Purpose : clocked observer of a sensitivity-list AND; y = a&b refreshed only on selected input changes.
// Latency : an input change settled before edge 1 shows on y / *_evt at edge SYNC_STAGES+1.
// Backpr. : none; free-running monitor, every sampled change is reported and nothing stalls.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   a, b         asynchronous operands (synchronized internally)
//   mode         00 = a and b, 01 = a only, 10 = b only, 11 = none
//   clr          synchronous clear of evt_cnt (wins over a coincident update)
//   y            registered AND, refreshed only on sensitive events
//   y_stale      y disagrees with the live synchronized a&b
//   a_evt, b_evt one-cycle pulse per detected change of a / b, independent of mode
//   evt_cnt      saturating count of y update events
//
// SYNC_STAGES is meant to stay within 2..4.
module and_sensitivity_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             y,
  output logic             y_stale,
  output logic             a_evt,
  output logic             b_evt,
  output logic [CNT_W-1:0] evt_cnt
);

  logic [SYNC_STAGES-1:0] a_sync;
  logic [SYNC_STAGES-1:0] b_sync;
  logic                   a_s, b_s;
  logic                   a_d, b_d;
  logic                   ch_a, ch_b;
  logic                   sens_a, sens_b;
  logic                   upd;
  logic                   live_and;
  logic                   y_next;

  // Synchronizer chains; bit 0 is the first flop, the MSB is the synchronized value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync <= '0;
      b_sync <= '0;
      a_d    <= 1'b0;
      b_d    <= 1'b0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], a};
      b_sync <= {b_sync[SYNC_STAGES-2:0], b};
      a_d    <= a_s;
      b_d    <= b_s;
    end
  end

  assign a_s      = a_sync[SYNC_STAGES-1];
  assign b_s      = b_sync[SYNC_STAGES-1];
  assign ch_a     = a_s ^ a_d;
  assign ch_b     = b_s ^ b_d;
  assign live_and = a_s & b_s;

  // Mode is applied combinationally so a mode change already governs this edge's update.
  assign sens_a = (mode == 2'b00) || (mode == 2'b01);
  assign sens_b = (mode == 2'b00) || (mode == 2'b10);
  assign upd    = (ch_a & sens_a) | (ch_b & sens_b);

  assign y_next = upd ? live_and : y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= 1'b0;
      y_stale <= 1'b0;
      a_evt   <= 1'b0;
      b_evt   <= 1'b0;
    end else begin
      y       <= y_next;
      // Compared against y_next so the flag lines up with the y it describes.
      y_stale <= (y_next != live_and);
      a_evt   <= ch_a;
      b_evt   <= ch_b;
    end
  end

  // Simultaneous a and b changes form a single update, so count upd, not the pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt <= '0;
    end else if (clr) begin
      evt_cnt <= '0;
    end else if (upd && (evt_cnt != {CNT_W{1'b1}})) begin
      evt_cnt <= evt_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_and_sensitivity_monitor.sv
// Purpose : directed scoreboard bench for and_sensitivity_monitor (SYNC_STAGES=2, CNT_W=2).
// Latency : expects pulses and y updates three edges after an input change.
// Backpr. : none; the monitor pops one expected record per evt pulse cycle.
module tb_and_sensitivity_monitor;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 2;

  typedef struct packed {
    logic             a_evt;
    logic             b_evt;
    logic             y;
    logic             y_stale;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             a;
  logic             b;
  logic [1:0]       mode;
  logic             clr;
  logic             y;
  logic             y_stale;
  logic             a_evt;
  logic             b_evt;
  logic [CNT_W-1:0] evt_cnt;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  and_sensitivity_monitor #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .mode   (mode),
    .clr    (clr),
    .y      (y),
    .y_stale(y_stale),
    .a_evt  (a_evt),
    .b_evt  (b_evt),
    .evt_cnt(evt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  // Monitor: sample 1 time unit after each rising edge; every evt pulse consumes one record.
  initial begin
    exp_t got;
    exp_t want;
    forever begin
      @(posedge clk);
      #1;
      if (a_evt || b_evt) begin
        got = '{a_evt, b_evt, y, y_stale, evt_cnt};
        if (exp_q.size() == 0) begin
          chk("unexpected_evt", {30'd0, a_evt, b_evt}, 32'd0);
        end else begin
          want = exp_q.pop_front();
          chk("evt_record", 32'(got), 32'(want));
        end
      end
    end
  end

  // Push the expected record, change inputs between edges, then let the result emerge.
  task automatic drive(input logic na, input logic nb, input logic [1:0] nm,
                       input logic ea, input logic eb, input logic ey, input logic es,
                       input logic [CNT_W-1:0] ec);
    @(posedge clk);
    #2;
    exp_q.push_back('{ea, eb, ey, es, ec});
    a    = na;
    b    = nb;
    mode = nm;
    repeat (5) @(posedge clk);
  endtask

  task automatic clear_cnt();
    @(posedge clk);
    #2 clr = 1'b1;
    @(posedge clk);
    #2 clr = 1'b0;
    chk("clr_cnt", 32'(evt_cnt), 32'd0);
  endtask

  initial begin
    int lat;
    logic es;
    rst_n = 1'b0;
    a     = 1'b1;
    b     = 1'b1;
    mode  = 2'b00;
    clr   = 1'b0;

    // Reset held with a=b=1: everything low.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y",       32'(y),       32'd0);
    chk("rst_y_stale", 32'(y_stale), 32'd0);
    chk("rst_evt",     {30'd0, a_evt, b_evt}, 32'd0);
    chk("rst_cnt",     32'(evt_cnt), 32'd0);

    // Release: both inputs appear as changes, one update, at edge 3.
    @(posedge clk);
    #2;
    exp_q.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 2'd1});
    rst_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (a_evt && lat == 0) lat = i;
    end
    chk("release_latency", 32'(lat), 32'(SYNC_STAGES + 1));

    // Mode 01: b change ignored (y stale), a change updates.
    clear_cnt();
    drive(1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
    drive(1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
    drive(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

    // Mode 10: a change ignored, two b changes update.
    drive(1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    drive(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3);

    // Mode 11: 10 toggles on each input; y stays 1, stale follows a&b.
    for (int k = 0; k < 10; k++) begin
      es = (1'b1 != ((~a) & b));
      drive(~a, b, 2'b11, 1'b1, 1'b0, 1'b1, es, 2'd3);
      es = (1'b1 != (a & (~b)));
      drive(a, ~b, 2'b11, 1'b0, 1'b1, 1'b1, es, 2'd3);
    end

    // Saturation at 3 with mode 00.
    clear_cnt();
    drive(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    drive(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2);
    drive(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
    drive(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3);
    drive(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3);

    // clr coincident with the update edge: y updates, count cleared.
    @(posedge clk);
    #2;
    exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 2'd0});
    a = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 clr = 1'b1;
    @(posedge clk);
    #2 clr = 1'b0;
    repeat (3) @(posedge clk);

    // Build y=1, cnt=2 before the mid-sync reset.
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2);

    // Async reset one cycle after an a toggle.
    @(posedge clk);
    #2 a = 1'b0;
    @(posedge clk);
    #3;
    chk("pre_rst_y",   32'(y),       32'd1);
    chk("pre_rst_cnt", 32'(evt_cnt), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_y",       32'(y),       32'd0);
    chk("async_rst_y_stale", 32'(y_stale), 32'd0);
    chk("async_rst_evt",     {30'd0, a_evt, b_evt}, 32'd0);
    chk("async_rst_cnt",     32'(evt_cnt), 32'd0);
    a = 1'b0;
    b = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_cnt", 32'(evt_cnt), 32'd0);
    chk("post_rst_y",   32'(y),       32'd0);

    // Every pushed expectation must have been consumed by an observed pulse.
    repeat (2) @(posedge clk);
    chk("pending_expected", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
